ct_mod_var: RTL and testbench
=============================

Name: ct_mod_var

Overview:
- Parametrised, runtime-configurable modulo counter. Successor to the fixed mod-N time-keeping counter.
- Adds: up/down counting, synchronous load, a runtime modulus (e.g. days-in-month, 12/24 h), a non-zero range base (e.g. 1..12), a registered wrap pulse and a cascade-ready terminal-count output.
- Instances are chained (sec -> min -> hr -> day) by feeding one stage's tc into the next stage's en.

Parameters:
- W, 7, counter width in bits.
- N_DEF, 60, modulus used when mod_in == 0.
- START, 0, lowest count value. Counting range is START..TOP, where TOP = START + M - 1.
- Constraint: START + N_DEF - 1 <= 2^W - 1, checked by elaboration-time assertion.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous clear to START (early reset, e.g. alarm-set).
- en   in  1  count enable, one step per cycle while high.
- dn   in  1  direction: 0 = up, 1 = down.
- ld   in  1  synchronous load of ld_val.
- ld_val  in  W  load value.
- mod_in  in  W  runtime modulus M; 0 selects N_DEF.
- ct_out  out  W  registered count.
- wrap  out  1  registered; high for exactly the cycle in which ct_out shows a value produced by a wrap.
- tc  out  1  combinational terminal count: en & (dn ? ct_out==START : ct_out==TOP).
- at_top  out  1  combinational: ct_out == TOP, independent of en/dn.

Behaviour:
- Reset: ct_out = START, wrap = 0. tc and at_top follow from ct_out and the inputs.
- M = (mod_in == 0) ? N_DEF : mod_in. TOP and all range compares computed in W+1 bits, so START + M - 1 never overflows. If TOP exceeds 2^W - 1, TOP is clamped to 2^W - 1.
- Priority per edge: rst > clr > ld > en > hold.
- clr: ct_out <= START, wrap <= 0.
- ld: ct_out <= ld_val if START <= ld_val <= TOP, else START. wrap <= 0.
- en, up:
  - ct_out >= TOP: ct_out <= START, wrap <= 1.
  - otherwise: ct_out <= ct_out + 1, wrap <= 0.
- en, down:
  - ct_out <= START or ct_out > TOP: ct_out <= TOP, wrap <= 1.
  - otherwise: ct_out <= ct_out - 1, wrap <= 0.
- Hold (no clr/ld/en): ct_out unchanged, wrap <= 0.
- Runtime mod_in change: takes effect combinationally on TOP.
  - If ct_out is now above TOP, it holds until the next enabled step, which wraps as above (to START when up, to TOP when down). No illegal value is produced by counting.
- Latency: ct_out updates one cycle after the qualifying input. tc is zero-latency, so a cascaded stage increments on the same edge the lower stage wraps.
- M == 1: every enabled step is a wrap; ct_out stays at START; wrap is high each enabled cycle.
- dn may change on any cycle; each step uses the dn value sampled at that edge.

Optional Feature:
- Macro CT_BCD_OUT_EN.
- Defined:
  - Extra output port bcd_out[7:0]: registered two-digit BCD of the next count, updated on the same edge as ct_out.
  - Reset value is BCD(START).
  - Values above 99 saturate to 8'h99.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- rst 1 cycle, START=0, N_DEF=60, en=1, dn=0 for 61 cycles -> ct_out 0..59 then 0; wrap high only in the cycle ct_out = 0 after 59; tc high while ct_out = 59.
- START=1, mod_in=12, dn=1, ct_out=1, en pulse -> ct_out=12, wrap=1; next en -> 11, wrap=0.
- ld=1, ld_val=45, mod_in=31 (TOP=30, START=0) -> ct_out=0; then ld_val=20 -> ct_out=20.
- ct_out=29 at mod_in=60, switch mod_in=28, en up -> ct_out=0, wrap=1.
- rst=1, clr=1, ld=1, en=1 on the same edge -> ct_out=START. With clr=1, ld=1 only -> START. With ld=1, en=1 -> ld_val wins.
- Two chained instances (sec.tc -> min.en), sec=59, min=59, en=1 -> both 0 on the same edge, both wrap=1. With CT_BCD_OUT_EN: bcd_out=8'h59 before that edge, 8'h00 after.

Source files
------------

// File: rtl/ct_mod_var.sv
// Runtime-configurable modulo counter (up/down, load, range base, wrap pulse, cascade tc).
// Optional macro CT_BCD_OUT_EN adds a registered two-digit BCD copy of the count.
module ct_mod_var #(
    parameter int W     = 7,
    parameter int N_DEF = 60,
    parameter int START = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         dn,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] mod_in,
    output logic [W-1:0] ct_out,
    output logic         wrap,
    output logic         tc,
    output logic         at_top
`ifdef CT_BCD_OUT_EN
    ,
    output logic [7:0]   bcd_out
`endif
);

    localparam logic [W:0]   START_X = (W+1)'(START);
    localparam logic [W:0]   NDEF_X  = (W+1)'(N_DEF);
    localparam logic [W:0]   MAX_X   = {1'b0, {W{1'b1}}};
    localparam logic [W:0]   ONE_X   = (W+1)'(1);
    localparam logic [W-1:0] START_V = W'(START);
    localparam logic [W-1:0] ONE_V   = W'(1);

    generate
        if (START < 0 || N_DEF < 1 || START + N_DEF - 1 > (2 ** W) - 1) begin : g_param_check
            $error("ct_mod_var: START + N_DEF - 1 must fit in W bits");
        end
    endgenerate

    logic [W:0]   m_x;
    logic [W:0]   top_sum;
    logic [W:0]   top_x;
    logic [W:0]   ct_x;
    logic [W:0]   ld_x;
    logic         ld_ok;
    logic [W-1:0] next_ct;
    logic         next_wrap;

    // Range math is one bit wider so START + M - 1 cannot overflow before clamping.
    always_comb begin
        m_x     = (mod_in == '0) ? NDEF_X : {1'b0, mod_in};
        top_sum = START_X + m_x - ONE_X;
        top_x   = (top_sum > MAX_X) ? MAX_X : top_sum;
    end

    assign ct_x   = {1'b0, ct_out};
    assign ld_x   = {1'b0, ld_val};
    assign ld_ok  = (ld_x >= START_X) && (ld_x <= top_x);
    assign at_top = (ct_x == top_x);
    assign tc     = en & (dn ? (ct_out == START_V) : (ct_x == top_x));

    always_comb begin
        next_ct   = ct_out;
        next_wrap = 1'b0;
        if (clr) begin
            next_ct = START_V;
        end else if (ld) begin
            next_ct = ld_ok ? ld_val : START_V;
        end else if (en) begin
            if (!dn) begin
                if (ct_x >= top_x) begin
                    next_ct   = START_V;
                    next_wrap = 1'b1;
                end else begin
                    next_ct = ct_out + ONE_V;
                end
            end else begin
                // A value stranded above a freshly lowered TOP also wraps to TOP.
                if (ct_x <= START_X || ct_x > top_x) begin
                    next_ct   = top_x[W-1:0];
                    next_wrap = 1'b1;
                end else begin
                    next_ct = ct_out - ONE_V;
                end
            end
        end
    end

`ifdef CT_BCD_OUT_EN
    function automatic logic [7:0] to_bcd(input logic [W-1:0] v);
        int unsigned iv;
        iv = 32'(v);
        if (iv > 99) return 8'h99;
        return {4'(iv / 10), 4'(iv % 10)};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) bcd_out <= to_bcd(START_V);
        else     bcd_out <= to_bcd(next_ct);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ct_out <= START_V;
            wrap   <= 1'b0;
        end else begin
            ct_out <= next_ct;
            wrap   <= next_wrap;
        end
    end

endmodule

// File: tb/tb_ct_mod_var.sv
// Self-checking bench for ct_mod_var: directed steps plus random traffic against an integer model.
// Three instances: a (START=0), b (cascaded from a.tc), c (START=1).
module tb_ct_mod_var;

    localparam int W     = 7;
    localparam int N_DEF = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, clr, ld, en, dn, ld_b;
    logic [W-1:0] ld_val, mod_in, ld_val_b;
    logic [W-1:0] ct_a, ct_b, ct_c;
    logic         wrap_a, wrap_b, wrap_c;
    logic         tc_a, tc_b, tc_c;
    logic         at_top_a, at_top_b, at_top_c;
`ifdef CT_BCD_OUT_EN
    logic [7:0]   bcd_a, bcd_b, bcd_c;
`endif

    ct_mod_var #(.W(W), .N_DEF(N_DEF), .START(0)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .dn(dn), .ld(ld),
        .ld_val(ld_val), .mod_in(mod_in), .ct_out(ct_a), .wrap(wrap_a),
        .tc(tc_a), .at_top(at_top_a)
`ifdef CT_BCD_OUT_EN
        , .bcd_out(bcd_a)
`endif
    );

    ct_mod_var #(.W(W), .N_DEF(N_DEF), .START(0)) u_b (
        .clk(clk), .rst(rst), .clr(1'b0), .en(tc_a), .dn(1'b0), .ld(ld_b),
        .ld_val(ld_val_b), .mod_in(7'd0), .ct_out(ct_b), .wrap(wrap_b),
        .tc(tc_b), .at_top(at_top_b)
`ifdef CT_BCD_OUT_EN
        , .bcd_out(bcd_b)
`endif
    );

    ct_mod_var #(.W(W), .N_DEF(N_DEF), .START(1)) u_c (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .dn(dn), .ld(ld),
        .ld_val(ld_val), .mod_in(mod_in), .ct_out(ct_c), .wrap(wrap_c),
        .tc(tc_c), .at_top(at_top_c)
`ifdef CT_BCD_OUT_EN
        , .bcd_out(bcd_c)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt[3];
    int wr[3];
    int st[3] = '{0, 0, 1};

    function automatic int top_of(int s, int mi);
        int m;
        int t;
        m = (mi == 0) ? N_DEF : mi;
        t = s + m - 1;
        if (t > (2 ** W) - 1) t = (2 ** W) - 1;
        return t;
    endfunction

    function automatic bit exp_tc(int k, bit e, bit d, int mi);
        return e && (d ? (cnt[k] == st[k]) : (cnt[k] == top_of(st[k], mi)));
    endfunction

    function automatic logic [7:0] exp_bcd(int v);
        if (v > 99) return 8'h99;
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    // Reference behaviour of one counter for one clock edge, in plain integers.
    function automatic void model_step(int k, bit r, bit c, bit l, int lv, bit e, bit d, int mi);
        int t;
        t     = top_of(st[k], mi);
        wr[k] = 0;
        if (r || c) begin
            cnt[k] = st[k];
        end else if (l) begin
            cnt[k] = (lv >= st[k] && lv <= t) ? lv : st[k];
        end else if (e) begin
            if (!d) begin
                if (cnt[k] >= t) begin cnt[k] = st[k]; wr[k] = 1; end
                else cnt[k] = cnt[k] + 1;
            end else begin
                if (cnt[k] <= st[k] || cnt[k] > t) begin cnt[k] = t; wr[k] = 1; end
                else cnt[k] = cnt[k] - 1;
            end
        end
    endfunction

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_regs();
        check_output("ct_a", 8'(ct_a), 8'(cnt[0]));
        check_output("ct_b", 8'(ct_b), 8'(cnt[1]));
        check_output("ct_c", 8'(ct_c), 8'(cnt[2]));
        check_output("wrap_a", 8'(wrap_a), 8'(wr[0]));
        check_output("wrap_b", 8'(wrap_b), 8'(wr[1]));
        check_output("wrap_c", 8'(wrap_c), 8'(wr[2]));
`ifdef CT_BCD_OUT_EN
        check_output("bcd_a", bcd_a, exp_bcd(cnt[0]));
        check_output("bcd_b", bcd_b, exp_bcd(cnt[1]));
        check_output("bcd_c", bcd_c, exp_bcd(cnt[2]));
`endif
    endtask

    // Checks combinational outputs for the driven inputs, clocks once, then checks registers.
    task automatic apply_stimulus();
        bit ta;
        int mi;
        mi = int'(mod_in);
        #1;
        ta = exp_tc(0, en, dn, mi);
        check_output("tc_a", 8'(tc_a), 8'(ta));
        check_output("tc_b", 8'(tc_b), 8'(exp_tc(1, ta, 1'b0, 0)));
        check_output("tc_c", 8'(tc_c), 8'(exp_tc(2, en, dn, mi)));
        check_output("at_top_a", 8'(at_top_a), 8'(cnt[0] == top_of(0, mi)));
        check_output("at_top_b", 8'(at_top_b), 8'(cnt[1] == top_of(0, 0)));
        check_output("at_top_c", 8'(at_top_c), 8'(cnt[2] == top_of(1, mi)));
        @(posedge clk);
        model_step(0, rst, clr, ld, int'(ld_val), en, dn, mi);
        model_step(1, rst, 1'b0, ld_b, int'(ld_val_b), ta, 1'b0, 0);
        model_step(2, rst, clr, ld, int'(ld_val), en, dn, mi);
        #1;
        check_regs();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; ld = 1'b0; en = 1'b0; dn = 1'b0; ld_b = 1'b0;
        ld_val = '0; mod_in = '0; ld_val_b = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin cnt[k] = st[k]; wr[k] = 0; end
        check_regs();
        rst = 1'b0;

        $display("[TB] free-running up count through a wrap");
        en = 1'b1;
        for (int i = 0; i < 61; i++) apply_stimulus();

        $display("[TB] START=1 down wrap with mod 12");
        en = 1'b0; clr = 1'b1;
        apply_stimulus();
        clr = 1'b0; en = 1'b1; dn = 1'b1; mod_in = 7'd12;
        apply_stimulus();
        check_output("c_dn_wrap_ct", 8'(ct_c), 8'd12);
        check_output("c_dn_wrap_pulse", 8'(wrap_c), 8'd1);
        apply_stimulus();
        check_output("c_dn_step_ct", 8'(ct_c), 8'd11);

        $display("[TB] load range check");
        en = 1'b0; dn = 1'b0; ld = 1'b1; ld_val = 7'd45; mod_in = 7'd31;
        apply_stimulus();
        check_output("ld_out_of_range", 8'(ct_a), 8'd0);
        ld_val = 7'd20;
        apply_stimulus();
        check_output("ld_in_range", 8'(ct_a), 8'd20);

        $display("[TB] modulus lowered below count");
        ld_val = 7'd29; mod_in = 7'd60;
        apply_stimulus();
        ld = 1'b0; en = 1'b1; mod_in = 7'd28;
        apply_stimulus();
        check_output("mod_shrink_ct", 8'(ct_a), 8'd0);
        check_output("mod_shrink_wrap", 8'(wrap_a), 8'd1);

        $display("[TB] control priority");
        rst = 1'b1; clr = 1'b1; ld = 1'b1; en = 1'b1; ld_val = 7'd10; mod_in = 7'd0;
        apply_stimulus();
        check_output("prio_rst", 8'(ct_a), 8'd0);
        rst = 1'b0; clr = 1'b0; en = 1'b0; ld_val = 7'd40;
        apply_stimulus();
        clr = 1'b1;
        apply_stimulus();
        check_output("prio_clr_over_ld", 8'(ct_a), 8'd0);
        clr = 1'b0; en = 1'b1; ld_val = 7'd33;
        apply_stimulus();
        check_output("prio_ld_over_en", 8'(ct_a), 8'd33);

        $display("[TB] cascade 59:59 rollover");
        en = 1'b0; ld_val = 7'd59; ld_b = 1'b1; ld_val_b = 7'd59;
        apply_stimulus();
`ifdef CT_BCD_OUT_EN
        check_output("bcd_b_before", bcd_b, 8'h59);
`endif
        ld = 1'b0; ld_b = 1'b0; en = 1'b1;
        apply_stimulus();
        check_output("chain_sec_ct", 8'(ct_a), 8'd0);
        check_output("chain_min_ct", 8'(ct_b), 8'd0);
        check_output("chain_sec_wrap", 8'(wrap_a), 8'd1);
        check_output("chain_min_wrap", 8'(wrap_b), 8'd1);
`ifdef CT_BCD_OUT_EN
        check_output("bcd_b_after", bcd_b, 8'h00);
`endif

        $display("[TB] modulus of one");
        mod_in = 7'd1;
        for (int i = 0; i < 4; i++) begin
            dn = 1'(i % 2);
            apply_stimulus();
            check_output("m1_ct", 8'(ct_a), 8'd0);
            check_output("m1_wrap", 8'(wrap_a), 8'd1);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            clr      = ($urandom_range(0, 31) == 0);
            ld       = ($urandom_range(0, 15) == 0);
            ld_b     = ($urandom_range(0, 31) == 0);
            ld_val   = 7'($urandom_range(0, 127));
            ld_val_b = 7'($urandom_range(0, 70));
            en       = ($urandom_range(0, 3) != 0);
            dn       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mod_in = 7'd0;
                    1:       mod_in = 7'($urandom_range(0, 127));
                    2:       mod_in = 7'($urandom_range(1, 15));
                    default: mod_in = 7'd60;
                endcase
            end
            apply_stimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
